// File: rtl/dac_sample_stage.sv
// dac_sample_stage: gain scale, clamp, FIFO and paced release of samples
// to a 10-bit parallel DAC.
//
// Ports (rst is async active-low):
//   clk, rst, enable                  clock, reset, stream enable
//   sample_valid/_data/_ready         upstream handshake
//   gain_in/gain_load                 Q1.3 gain (8 = unity) capture
//   period_in/period_load             update period (one update per P+1 clks)
//   underrun_clr                      clears the sticky underrun flag
//   dac_data, dac_update, underrun    DAC word, update pulse, sticky flag
//
// Build option DAC_STAGE_MIDSCALE_EN: drive midscale (with an update pulse)
// on underrun and on entry to IDLE instead of holding the last word.

module dac_sample_stage #(
  parameter int DW        = 10,
  parameter int DEPTH     = 8,
  parameter int PERIOD_W  = 16,
  parameter int PRIME_LVL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [DW-1:0]       sample_data,
  output logic                sample_ready,
  input  logic [3:0]          gain_in,
  input  logic                gain_load,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_load,
  input  logic                underrun_clr,
  output logic [DW-1:0]       dac_data,
  output logic                dac_update,
  output logic                underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = DW + 5;

  localparam logic [DW-1:0]        MID   = DW'(1 << (DW-1));
  localparam logic signed [DW:0]   MID_D = (DW+1)'(1 << (DW-1));
  localparam logic signed [PW-1:0] MID_P = PW'(1 << (DW-1));
  localparam logic signed [PW-1:0] MAX_P = PW'((1 << DW) - 1);
  localparam logic [CW-1:0]        PRIME = CW'(PRIME_LVL);
  localparam logic [CW-1:0]        FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    STARVED
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            gain_q, gain_d;
  logic [PERIOD_W-1:0]   shadow_q, shadow_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   tcnt_q, tcnt_d;
  logic                  s1_v_q, s1_v_d;
  logic signed [PW-1:0]  s1_p_q, s1_p_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dac_q, dac_d;
  logic                  upd_q, upd_d;
  logic                  und_q, und_d;
  logic                  rdy_q, rdy_d;
  logic [DW-1:0]         mem [DEPTH];

  logic                  flush;
  logic                  xfer;
  logic                  tick;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic signed [DW:0]    s1_d;
  logic signed [PW-1:0]  d_ext;
  logic signed [PW-1:0]  g_ext;
  logic signed [PW-1:0]  r;
  logic [DW-1:0]         wdata;
  logic [CW-1:0]         occ;

  assign sample_ready = rdy_q;
  assign dac_data     = dac_q;
  assign dac_update   = upd_q;
  assign underrun     = und_q;

  // S1: centre on midscale and multiply by the gain in force now
  assign s1_d   = $signed({1'b0, sample_data}) - MID_D;
  assign d_ext  = PW'(s1_d);
  assign g_ext  = PW'($signed({1'b0, gain_q}));
  assign s1_p_d = d_ext * g_ext;

  // S2: drop the Q1.3 fraction, re-bias and clamp into DAC range
  assign r = (s1_p_q >>> 3) + MID_P;

  always_comb begin
    wdata = r[DW-1:0];
    if (r[PW-1]) begin
      wdata = '0;
    end else if (r > MAX_P) begin
      wdata = '1;
    end
  end

  assign flush = (state_q == IDLE) || !enable;
  assign xfer  = sample_valid && rdy_q;
  assign empty = (cnt_q == '0);
  assign tick  = (state_q == RUN) && enable
               && (tcnt_q == period_q);
  assign push  = s1_v_q && !flush;
  assign pop   = tick && !empty;

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_load ? gain_in : gain_q;
    shadow_d = period_load ? period_in : shadow_q;
    period_d = period_q;
    tcnt_d   = '0;
    dac_d    = dac_q;
    upd_d    = 1'b0;
    und_d    = underrun_clr ? 1'b0 : und_q;
    s1_v_d   = 1'b0;
    wp_d     = '0;
    rp_d     = '0;
    cnt_d    = '0;

    unique case (state_q)
      IDLE:    if (enable) state_d = FILL;
      FILL:    if (cnt_q >= PRIME) state_d = RUN;
      RUN:     if (tick && empty) state_d = STARVED;
      STARVED: state_d = FILL;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;

    if (pop) begin
      dac_d = mem[rp_q];
      upd_d = 1'b1;
    end

    if (tick && empty) begin
      und_d = 1'b1;
`ifdef DAC_STAGE_MIDSCALE_EN
      dac_d = MID;
      upd_d = 1'b1;
`endif
    end

`ifdef DAC_STAGE_MIDSCALE_EN
    if (state_q != IDLE && state_d == IDLE) begin
      dac_d = MID;
      upd_d = 1'b1;
    end
`endif

    // Counter only runs while staying in RUN; wrap doubles as tick
    if (state_q == RUN && state_d == RUN) begin
      tcnt_d = tick ? '0 : tcnt_q + PERIOD_W'(1);
    end

    if (state_q != RUN || tick) begin
      period_d = shadow_d;
    end

    if (!flush) begin
      s1_v_d = xfer;
      wp_d   = wp_q + AW'(push);
      rp_d   = rp_q + AW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    // Ready looks at next-cycle occupancy so a registered ready can
    // never admit a sample the FIFO has no room for
    occ   = cnt_d + CW'(s1_v_d);
    rdy_d = enable && (state_d != IDLE) && (occ < FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gain_q   <= 4'd8;
      shadow_q <= '0;
      period_q <= '0;
      tcnt_q   <= '0;
      s1_v_q   <= 1'b0;
      s1_p_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      dac_q    <= MID;
      upd_q    <= 1'b0;
      und_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
      tcnt_q   <= tcnt_d;
      s1_v_q   <= s1_v_d;
      s1_p_q   <= s1_p_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      upd_q    <= upd_d;
      und_q    <= und_d;
      rdy_q    <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wdata;
  end

endmodule

// File: tb/tb_dac_sample_stage.sv
// tb_dac_sample_stage: directed checks of scaling, pacing, underrun,
// backpressure and reset for dac_sample_stage.

module tb_dac_sample_stage;

`ifdef DAC_STAGE_MIDSCALE_EN
  localparam bit MID_EN = 1'b1;
`else
  localparam bit MID_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_data = '0;
  logic        sample_ready;
  logic [3:0]  gain_in = 4'd8;
  logic        gain_load = 1'b0;
  logic [15:0] period_in = '0;
  logic        period_load = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [9:0]  dac_data;
  logic        dac_update;
  logic        underrun;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int nok    = 0;
  logic [9:0] uq[$];
  int         ut[$];

  dac_sample_stage dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .gain_in      (gain_in),
    .gain_load    (gain_load),
    .period_in    (period_in),
    .period_load  (period_load),
    .underrun_clr (underrun_clr),
    .dac_data     (dac_data),
    .dac_update   (dac_update),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst && dac_update) begin
      uq.push_back(dac_data);
      ut.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] uq_at(input int i);
    return (i < uq.size()) ? uq[i] : 10'bx;
  endfunction

  function automatic int gap_at(input int i);
    return (i < ut.size() && i > 0) ? ut[i] - ut[i-1] : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    enable = 1'b0;
    sample_valid = 1'b0;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    cycles(3);
    uq.delete();
    ut.delete();
  endtask

  task automatic set_gain(input logic [3:0] g);
    gain_in = g;
    gain_load = 1'b1;
    @(negedge clk);
    gain_load = 1'b0;
  endtask

  task automatic set_period(input logic [15:0] p);
    period_in = p;
    period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
  endtask

  task automatic push(input logic [9:0] d);
    bit ok;
    ok = 1'b0;
    sample_valid = 1'b1;
    sample_data = d;
    for (int i = 0; i < 200; i++) begin
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else nok++;
    sample_valid = 1'b0;
  endtask

  task automatic wait_upd(input int n, input int budget);
    for (int i = 0; i < budget && uq.size() < n; i++)
      @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_unity();
    logic [9:0] exp [5];
    int bad;
    exp = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd500};
    flush();
    nok = 0;
    set_gain(4'd8);
    set_period(16'd3);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) push(exp[i]);
    wait_upd(5, 100);
    total++;
    if (nok !== 0) $display("FAIL unity_push timeouts got %0d want 0", nok);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (uq_at(i) !== exp[i])
        $display("FAIL unity_val[%0d] got %0d want %0d", i, uq_at(i), exp[i]);
      else passed++;
    end
    bad = 0;
    for (int i = 1; i < 5; i++) if (gap_at(i) != 4) bad++;
    total++;
    if (bad !== 0) $display("FAIL unity_gap bad gaps got %0d want 0", bad);
    else passed++;
    cycles(8);
    total++;
    if (underrun !== 1'b1) $display("FAIL unity_underrun got %b want 1", underrun);
    else passed++;
    total++;
    if (dac_data !== (MID_EN ? 10'd512 : 10'd500))
      $display("FAIL unity_hold got %0d want %0d", dac_data,
               MID_EN ? 512 : 500);
    else passed++;
  endtask

  task automatic test_scale();
    logic [9:0] exp [5];
    exp = '{10'd1023, 10'd0, 10'd512, 10'd767, 10'd512};
    flush();
    set_gain(4'd15);
    set_period(16'd3);
    enable = 1'b1;
    push(10'd1023);
    push(10'd0);
    push(10'd512);
    set_gain(4'd4);
    push(10'd1023);
    set_gain(4'd0);
    push(10'd900);
    wait_upd(5, 100);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (uq_at(i) !== exp[i])
        $display("FAIL scale_val[%0d] got %0d want %0d", i, uq_at(i), exp[i]);
      else passed++;
    end
  endtask

  task automatic test_gain_change();
    logic [9:0] exp [4];
    exp = '{10'd612, 10'd612, 10'd562, 10'd562};
    flush();
    set_gain(4'd8);
    enable = 1'b1;
    push(10'd612);
    push(10'd612);
    set_gain(4'd4);
    push(10'd612);
    push(10'd612);
    wait_upd(4, 100);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (uq_at(i) !== exp[i])
        $display("FAIL gain_val[%0d] got %0d want %0d", i, uq_at(i), exp[i]);
      else passed++;
    end
  endtask

  task automatic test_underrun();
    logic [9:0] exp [4];
    int bad;
    exp = '{10'd10, 10'd20, 10'd30, 10'd40};
    flush();
    set_gain(4'd8);
    set_period(16'd0);
    total++;
    if (underrun !== 1'b0) $display("FAIL und_pre got %b want 0", underrun);
    else passed++;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(exp[i]);
    wait_upd(4, 50);
    cycles(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (uq_at(i) !== exp[i])
        $display("FAIL und_val[%0d] got %0d want %0d", i, uq_at(i), exp[i]);
      else passed++;
    end
    bad = 0;
    for (int i = 1; i < 4; i++) if (gap_at(i) != 1) bad++;
    total++;
    if (bad !== 0) $display("FAIL und_gap bad gaps got %0d want 0", bad);
    else passed++;
    total++;
    if (uq.size() !== (MID_EN ? 5 : 4))
      $display("FAIL und_count got %0d want %0d", uq.size(), MID_EN ? 5 : 4);
    else passed++;
    total++;
    if (underrun !== 1'b1) $display("FAIL und_flag got %b want 1", underrun);
    else passed++;
    total++;
    if (dac_data !== (MID_EN ? 10'd512 : 10'd40))
      $display("FAIL und_hold got %0d want %0d", dac_data, MID_EN ? 512 : 40);
    else passed++;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    total++;
    if (underrun !== 1'b0) $display("FAIL und_clr got %b want 0", underrun);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit stop;
    int rdy_low;
    int n0;
    int bad;
    flush();
    set_gain(4'd8);
    set_period(16'd15);
    stop = 1'b0;
    rdy_low = 0;
    n0 = 0;
    enable = 1'b1;
    fork
      begin : driver
        logic [9:0] nxt;
        bit took;
        nxt = 10'd1;
        took = 1'b0;
        sample_data = nxt;
        sample_valid = 1'b1;
        while (!stop) begin
          @(negedge clk);
          if (took) begin
            nxt = nxt + 10'd1;
            sample_data = nxt;
          end
          took = sample_ready;
          if (!sample_ready && uq.size() > 0) rdy_low++;
        end
        sample_valid = 1'b0;
      end
      begin : main
        wait_upd(64, 64 * 16 + 200);
        n0 = uq.size();
        for (int i = 0; i < 40 && uq.size() <= n0; i++)
          @(negedge clk);
        n0 = uq.size() - 1;
        set_period(16'd1);
        wait_upd(n0 + 4, 100);
        stop = 1'b1;
      end
    join
    total++;
    if (rdy_low == 0) $display("FAIL bp_ready_low cycles got 0 want >0");
    else passed++;
    bad = 0;
    for (int i = 0; i < uq.size(); i++)
      if (uq[i] !== 10'(i + 1)) bad++;
    total++;
    if (bad !== 0 || uq.size() < 68)
      $display("FAIL bp_seq errors got %0d size %0d want 0 and >=68",
               bad, uq.size());
    else passed++;
    total++;
    if (gap_at(n0 + 1) != 16)
      $display("FAIL bp_gap_old got %0d want 16", gap_at(n0 + 1));
    else passed++;
    total++;
    if (gap_at(n0 + 2) != 2)
      $display("FAIL bp_gap_new1 got %0d want 2", gap_at(n0 + 2));
    else passed++;
    total++;
    if (gap_at(n0 + 3) != 2)
      $display("FAIL bp_gap_new2 got %0d want 2", gap_at(n0 + 3));
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    enable = 1'b1;
    cycles(3);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (dac_data !== 10'd512) $display("FAIL rst_dac got %0d want 512", dac_data);
    else passed++;
    total++;
    if (dac_update !== 1'b0) $display("FAIL rst_upd got %b want 0", dac_update);
    else passed++;
    total++;
    if (underrun !== 1'b0) $display("FAIL rst_und got %b want 0", underrun);
    else passed++;
    total++;
    if (sample_ready !== 1'b0) $display("FAIL rst_rdy got %b want 0", sample_ready);
    else passed++;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sample_ready !== 1'b0 || dac_data !== 10'd512
          || dac_update !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL rst_idle bad cycles got %0d want 0", bad);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    test_unity();
    test_scale();
    test_gain_change();
    test_underrun();
    test_back_to_back();
    test_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
